// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter with a registered register-file write port and
// a per-register busy scoreboard for WAW/RAW hazard checks at issue.
module writeback_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XLEN = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*5-1:0]    req_rd_i,
  input  logic [NREQ*XLEN-1:0] req_data_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_rd_o,
  output logic [XLEN-1:0]      rf_wdata_o,
  input  logic                 issue_valid_i,
  input  logic [4:0]           issue_rd_i,
  output logic                 issue_ready_o,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  output logic                 rs1_busy_o,
  output logic                 rs2_busy_o,
  input  logic                 flush_i
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [31:0]     busy_q, busy_d;

  logic            gnt_found;
  logic [PtrW-1:0] gnt_idx;
  logic [PtrW:0]   cand;
  logic [4:0]      gnt_rd;
  logic [XLEN-1:0] gnt_data;
  logic            issue_set;

  // Search upward from rr_ptr, wrapping at NREQ; the one extra bit of cand
  // holds the un-wrapped sum.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PtrW+1)'(k);
      if (cand >= (PtrW+1)'(NREQ)) begin
        cand = cand - (PtrW+1)'(NREQ);
      end
      if (!gnt_found && req_valid_i[cand[PtrW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PtrW-1:0];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (gnt_found) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  assign gnt_rd   = req_rd_i[5*gnt_idx +: 5];
  assign gnt_data = req_data_i[XLEN*gnt_idx +: XLEN];

  // A granted requester is always valid, so gnt_found is the handshake.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (gnt_found) begin
      rr_ptr_d   = (gnt_idx == PtrW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      rf_we_d    = (gnt_rd != 5'd0);
      rf_rd_d    = gnt_rd;
      rf_wdata_d = gnt_data;
    end
  end

  assign issue_ready_o = !((issue_rd_i != 5'd0) && busy_q[issue_rd_i]);
  assign issue_set     = issue_valid_i && issue_ready_o && (issue_rd_i != 5'd0);

  // Priority: flush over set over clear; x0 never becomes busy.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_rd_q] = 1'b0;
    end
    if (issue_set) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  assign rs1_busy_o = (rs1_i != 5'd0) && busy_q[rs1_i];
  assign rs2_busy_o = (rs2_i != 5'd0) && busy_q[rs2_i];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_rd_o    = rf_rd_q;
  assign rf_wdata_o = rf_wdata_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus randomized traffic,
// all checked against a behavioural model of arbitration and scoreboard.
module tb_writeback_arbiter;
  localparam int unsigned NREQ = 3;
  localparam int unsigned XLEN = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*5-1:0]    req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 rf_we;
  logic [4:0]           rf_rd;
  logic [XLEN-1:0]      rf_wdata;
  logic                 issue_valid;
  logic [4:0]           issue_rd;
  logic                 issue_ready;
  logic [4:0]           rs1, rs2;
  logic                 rs1_busy, rs2_busy;
  logic                 flush;

  writeback_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .req_valid_i(req_valid), .req_rd_i(req_rd), .req_data_i(req_data),
    .req_ready_o(req_ready),
    .rf_we_o(rf_we), .rf_rd_o(rf_rd), .rf_wdata_o(rf_wdata),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(issue_ready),
    .rs1_i(rs1), .rs2_i(rs2), .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
    .flush_i(flush)
  );

  always #5 clk = ~clk;

  // Stimulus for the next cycle, applied at the falling edge
  logic [NREQ-1:0]      st_valid;
  logic [NREQ*5-1:0]    st_rd;
  logic [NREQ*XLEN-1:0] st_data;
  logic                 st_iv, st_flush;
  logic [4:0]           st_ird, st_rs1, st_rs2;

  // Reference model state
  int          m_ptr;
  bit [31:0]   m_busy;
  bit          m_we;
  int          m_rd;
  logic [31:0] m_wdata;

  // Last observed values, for directed checks
  logic [NREQ-1:0] obs_ready;
  logic            obs_we, obs_ir, obs_rs1b, obs_rs2b;
  logic [4:0]      obs_rd;
  logic [31:0]     obs_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_busy = '0; m_we = 0; m_rd = 0; m_wdata = '0;
  endtask

  task automatic clr_stim();
    st_valid = '0; st_rd = '0; st_data = '0; st_iv = 0; st_flush = 0;
    st_ird = '0; st_rs1 = '0; st_rs2 = '0;
  endtask

  task automatic step();
    bit              found;
    int              g;
    logic [NREQ-1:0] exp_ready;
    bit              exp_ir;
    bit [31:0]       nb;
    @(negedge clk);
    check_eq("rf_we", rf_we, m_we);
    check_eq("rf_rd", rf_rd, m_rd);
    check_eq("rf_wdata", rf_wdata, m_wdata);
    obs_we = rf_we; obs_rd = rf_rd; obs_wdata = rf_wdata;
    req_valid = st_valid; req_rd = st_rd; req_data = st_data;
    issue_valid = st_iv; issue_rd = st_ird; rs1 = st_rs1; rs2 = st_rs2; flush = st_flush;
    #1;
    found = 0; g = 0;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (!found && st_valid[i]) begin found = 1; g = i; end
    end
    exp_ready = '0;
    if (found) exp_ready[g] = 1'b1;
    exp_ir = !(st_ird != 0 && m_busy[st_ird]);
    check_eq("req_ready", req_ready, exp_ready);
    check_eq("issue_ready", issue_ready, exp_ir);
    check_eq("rs1_busy", rs1_busy, st_rs1 != 0 && m_busy[st_rs1]);
    check_eq("rs2_busy", rs2_busy, st_rs2 != 0 && m_busy[st_rs2]);
    obs_ready = req_ready; obs_ir = issue_ready; obs_rs1b = rs1_busy; obs_rs2b = rs2_busy;
    if (rst_n) begin
      nb = m_busy;
      if (m_we) nb[m_rd] = 1'b0;
      if (st_iv && exp_ir && st_ird != 0) nb[st_ird] = 1'b1;
      if (st_flush) nb = '0;
      m_busy = nb;
      if (found) begin
        m_rd    = int'(st_rd[5*g +: 5]);
        m_we    = (m_rd != 0);
        m_wdata = st_data[XLEN*g +: XLEN];
        m_ptr   = (g + 1) % NREQ;
      end else begin
        m_we = 0;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clr_stim();
    req_valid = '0; req_rd = '0; req_data = '0; issue_valid = 0; issue_rd = '0;
    rs1 = '0; rs2 = '0; flush = 0;
    model_reset();
    #2;
    check_eq("rst_we", rf_we, 0);
    check_eq("rst_rd", rf_rd, 0);
    check_eq("rst_wdata", rf_wdata, 0);

    // Arbitration from pointer 0 while held in reset, without state change
    st_valid = 3'b110; st_rd = {5'd7, 5'd6, 5'd5};
    step();
    check_eq("rst_ready", obs_ready, 3'b010);
    step();
    check_eq("rst_hold_ready", obs_ready, 3'b010);
    #2 rst_n = 1'b1;

    // All requesting: grants rotate 0,1,2,0 and writes follow one cycle later
    st_valid = 3'b111; st_data = {32'hC, 32'hB, 32'hA};
    for (int n = 0; n < 4; n++) begin
      logic [NREQ-1:0] eg;
      eg = '0;
      eg[n % NREQ] = 1'b1;
      step();
      check_eq("rr_grant", obs_ready, eg);
      if (n > 0) check_eq("rr_we", obs_we, 1);
    end
    clr_stim();
    step();
    check_eq("rr_last_rd", obs_rd, 5);

    // Issue rd=9, then write 9 with DEADBEEF; a reissue of 9 is stalled meanwhile
    st_iv = 1; st_ird = 5'd9;
    step();
    st_valid = 3'b001; st_rd = {10'd0, 5'd9}; st_data = {64'd0, 32'hDEADBEEF}; st_rs1 = 5'd9;
    step();
    check_eq("waw_stall", obs_ir, 0);
    check_eq("rs1_busy9", obs_rs1b, 1);
    st_valid = '0; st_iv = 0;
    step();
    check_eq("wb9_we", obs_we, 1);
    check_eq("wb9_rd", obs_rd, 9);
    check_eq("wb9_data", obs_wdata, 32'hDEADBEEF);
    check_eq("rs1_busy9_we", obs_rs1b, 1);
    st_iv = 1;
    step();
    check_eq("rs1_free9", obs_rs1b, 0);
    check_eq("issue9_ok", obs_ir, 1);
    clr_stim();
    step();

    // Write to x0: accepted but no register-file write
    st_valid = 3'b001; st_rd = '0; st_data = {64'd0, 32'h1234};
    step();
    check_eq("x0_ready", obs_ready, 3'b001);
    clr_stim();
    step();
    check_eq("x0_we", obs_we, 0);

    // Issue of rd=4 lands on the same edge as the clear of busy[4]: set wins
    st_valid = 3'b001; st_rd = {10'd0, 5'd4};
    step();
    clr_stim();
    st_iv = 1; st_ird = 5'd4;
    step();
    check_eq("same_edge_we", obs_we, 1);
    clr_stim();
    st_rs1 = 5'd4;
    step();
    check_eq("same_edge_busy4", obs_rs1b, 1);

    // Busy on 3, 8, 12 then flush overrides a concurrent set of 5
    st_iv = 1;
    st_ird = 5'd3; step();
    st_ird = 5'd8; step();
    st_ird = 5'd12; step();
    st_ird = 5'd5; st_flush = 1; st_rs1 = 5'd3; st_rs2 = 5'd12;
    step();
    check_eq("pre_flush3", obs_rs1b, 1);
    clr_stim();
    st_rs1 = 5'd8; st_rs2 = 5'd5;
    step();
    check_eq("flush8", obs_rs1b, 0);
    check_eq("flush5", obs_rs2b, 0);
    st_rs1 = 5'd3; st_rs2 = 5'd12;
    step();
    check_eq("flush3", obs_rs1b, 0);
    check_eq("flush12", obs_rs2b, 0);

    // Reset asserted with a write on the port clears it at once and drops the next one
    st_valid = 3'b001; st_rd = {10'd0, 5'd6}; st_data = {64'd0, 32'h55};
    step();
    step();
    #1;
    check_eq("pre_rst_we", rf_we, 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_we", rf_we, 0);
    check_eq("async_rst_rd", rf_rd, 0);
    model_reset();
    step();
    #2 rst_n = 1'b1;
    clr_stim();
    step();
    check_eq("post_rst_we", obs_we, 0);

    // Randomized traffic over a small register range to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      st_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        st_rd[5*i +: 5]         = 5'($urandom_range(0, 7));
        st_data[XLEN*i +: XLEN] = $urandom;
      end
      st_iv    = 1'($urandom_range(0, 1));
      st_ird   = 5'($urandom_range(0, 7));
      st_rs1   = 5'($urandom_range(0, 7));
      st_rs2   = 5'($urandom_range(0, 7));
      st_flush = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
